// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants and types for the 4-digit multiplexed seven-segment display.
//   SEG7_HEX   : 16-entry hex glyph table, active-high, bit0 = a .. bit6 = g
//   NUM_DIGITS : number of multiplexed digits
//   SEG_OFF    : all segments off (active-high)
//   disp_pat_t : one output slot pattern {an, dp, seg}
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_OFF = 7'h00;

    localparam logic [6:0] SEG7_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef logic [$clog2(NUM_DIGITS)-1:0] digit_idx_t;

    typedef struct packed {
        logic [NUM_DIGITS-1:0] an;
        logic                  dp;
        logic [6:0]            seg;
    } disp_pat_t;

endpackage

// File: rtl/hex_to_seg7.sv
// -----------------------------------------------------------------------------
// hex_to_seg7
// Combinational hex nibble to seven-segment decoder (active-high).
//   nibble_i [3:0] : hex digit
//   seg_o    [6:0] : segments, bit0 = a .. bit6 = g
// -----------------------------------------------------------------------------
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG7_HEX[nibble_i];

endmodule

// File: rtl/seg7_result_display.sv
// -----------------------------------------------------------------------------
// seg7_result_display
// Captures a 16-bit debug word on a strobe and scans it out as four hex digits
// on a multiplexed seven-segment display.
//   clk, rst          : board clock, asynchronous active-high reset
//   value[15:0]       : word to display, captured when value_valid = 1
//   value_valid       : single-cycle capture strobe
//   dp_mask[3:0]      : decimal point enable per digit (live)
//   blank_lz          : leading-zero blanking enable (live)
//   seg[6:0], dp, an[3:0] : registered display outputs, polarity set by
//                       ACTIVE_LOW
// -----------------------------------------------------------------------------
module seg7_result_display
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           value,
    input  logic                  value_valid,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int            CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(REFRESH_DIV - 1);
    // Pattern XOR mask: active-high "off" is all zeros, so the off value at
    // the pins is simply the mask itself.
    localparam disp_pat_t     POL_MASK = disp_pat_t'({$bits(disp_pat_t){ACTIVE_LOW}});

    logic [CW-1:0]         cnt_q, cnt_d;
    digit_idx_t            idx_q, idx_d, nxt_idx;
    logic [15:0]           shadow_q, shadow_d;
    disp_pat_t             out_q, out_d, pat;
    logic                  tick;
    logic [3:0]            nib;
    logic [6:0]            nib_seg;
    // allz[n]: nibbles NUM_DIGITS-1 .. n of the shadow are all zero
    logic [NUM_DIGITS-1:0] allz;

    assign tick    = (cnt_q == CNT_MAX);
    assign nxt_idx = digit_idx_t'(idx_q + 1'b1);
    assign nib     = shadow_q[4*nxt_idx +: 4];

    hex_to_seg7 u_dec (
        .nibble_i (nib),
        .seg_o    (nib_seg)
    );

    always_comb begin
        allz = '0;
        allz[NUM_DIGITS-1] = (shadow_q[4*(NUM_DIGITS-1) +: 4] == 4'h0);
        for (int n = NUM_DIGITS - 2; n >= 0; n--) begin
            allz[n] = allz[n+1] && (shadow_q[4*n +: 4] == 4'h0);
        end
    end

    always_comb begin
        cnt_d    = tick ? '0 : cnt_q + 1'b1;
        idx_d    = tick ? nxt_idx : idx_q;
        shadow_d = value_valid ? value : shadow_q;

        pat     = '0;
        pat.seg = nib_seg;
        pat.dp  = dp_mask[nxt_idx];
        pat.an  = NUM_DIGITS'(1) << nxt_idx;
        // Digit 0 always shows, so a zero word still reads "0".
        if (blank_lz && (nxt_idx != '0) && allz[nxt_idx]) begin
            pat.seg = SEG_OFF;
            pat.dp  = 1'b0;
            pat.an  = '0;
        end

        out_d = tick ? (pat ^ POL_MASK) : out_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            idx_q    <= digit_idx_t'(NUM_DIGITS - 1);
            shadow_q <= '0;
            out_q    <= POL_MASK;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            out_q    <= out_d;
        end
    end

    assign seg = out_q.seg;
    assign dp  = out_q.dp;
    assign an  = out_q.an;

endmodule

// File: tb/tb_seg7_result_display.sv
module tb_seg7_result_display;

    localparam int NI = 3;
    localparam int DIV [NI] = '{4, 4, 1};
    localparam bit AL  [NI] = '{1'b0, 1'b1, 1'b0};
    localparam logic [6:0] HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = '0;
    logic        value_valid = 1'b0;
    logic [3:0]  dp_mask = '0;
    logic        blank_lz = 1'b0;

    logic [6:0]  seg_w [NI];
    logic        dp_w  [NI];
    logic [3:0]  an_w  [NI];

    logic [6:0]  exp_seg [NI];
    logic        exp_dp  [NI];
    logic [3:0]  exp_an  [NI];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seg7_result_display #(.REFRESH_DIV(4), .ACTIVE_LOW(1'b0)) u_d0 (
        .clk(clk), .rst(rst), .value(value), .value_valid(value_valid),
        .dp_mask(dp_mask), .blank_lz(blank_lz),
        .seg(seg_w[0]), .dp(dp_w[0]), .an(an_w[0]));
    seg7_result_display #(.REFRESH_DIV(4), .ACTIVE_LOW(1'b1)) u_d1 (
        .clk(clk), .rst(rst), .value(value), .value_valid(value_valid),
        .dp_mask(dp_mask), .blank_lz(blank_lz),
        .seg(seg_w[1]), .dp(dp_w[1]), .an(an_w[1]));
    seg7_result_display #(.REFRESH_DIV(1), .ACTIVE_LOW(1'b0)) u_d2 (
        .clk(clk), .rst(rst), .value(value), .value_valid(value_valid),
        .dp_mask(dp_mask), .blank_lz(blank_lz),
        .seg(seg_w[2]), .dp(dp_w[2]), .an(an_w[2]));

    // Reference model: k counts clock edges since reset; edge k shows a new
    // digit whenever k is a multiple of the slot length, and that digit is
    // (k/DIV - 1) mod 4. The pattern uses the word held before the edge.
    int          k;
    logic [15:0] m_shadow;

    function automatic logic [11:0] expect_pat(int d, logic [15:0] sh,
                                               logic [3:0] dpm, logic blz, bit al);
        logic [6:0]  s;
        logic        p;
        logic [3:0]  a;
        int          nibv;
        nibv = int'((sh >> (4 * d)) & 16'hF);
        if (blz && d > 0 && (sh >> (4 * d)) == 16'h0) begin
            s = 7'h00; p = 1'b0; a = 4'h0;
        end else begin
            s = HEX[nibv]; p = dpm[d]; a = 4'(1 << d);
        end
        if (al) return ~{a, p, s};
        return {a, p, s};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            k        = 0;
            m_shadow = 16'h0;
            for (int i = 0; i < NI; i++)
                {exp_an[i], exp_dp[i], exp_seg[i]} = AL[i] ? 12'hFFF : 12'h000;
        end else begin
            k++;
            for (int i = 0; i < NI; i++) begin
                if (k % DIV[i] == 0)
                    {exp_an[i], exp_dp[i], exp_seg[i]} =
                        expect_pat(((k / DIV[i]) - 1) % 4, m_shadow, dp_mask, blank_lz, AL[i]);
            end
            if (value_valid) m_shadow = value;
        end
    end

    task automatic check_all(input string tag);
        for (int i = 0; i < NI; i++) begin
            checks++;
            assert (seg_w[i] === exp_seg[i]) else begin
                failures++;
                $error("FAIL %s inst%0d seg got=%h exp=%h", tag, i, seg_w[i], exp_seg[i]);
            end
            checks++;
            assert (dp_w[i] === exp_dp[i]) else begin
                failures++;
                $error("FAIL %s inst%0d dp got=%b exp=%b", tag, i, dp_w[i], exp_dp[i]);
            end
            checks++;
            assert (an_w[i] === exp_an[i]) else begin
                failures++;
                $error("FAIL %s inst%0d an got=%b exp=%b", tag, i, an_w[i], exp_an[i]);
            end
        end
    endtask

    task automatic step(input string tag);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, want);
        end
    endtask

    task automatic pulse(input logic [15:0] v, input string tag);
        value = v;
        value_valid = 1'b1;
        step(tag);
        value_valid = 1'b0;
    endtask

    logic [6:0] got_seg [4];
    int         n0, nblank, guard;

    initial begin
        // Reset state
        repeat (2) step("reset");
        chk("reset_an0", 16'(an_w[0]), 16'h0);
        chk("reset_an1", 16'(an_w[1]), 16'hF);
        chk("reset_seg1", 16'(seg_w[1]), 16'h7F);

        // First frame: off for DIV-1 edges, then digit 0 = "0"
        rst = 1'b0;
        repeat (3) step("pre_tick");
        chk("pre_tick_an0", 16'(an_w[0]), 16'h0);
        step("first_tick");
        chk("first_tick_an0", 16'(an_w[0]), 16'h1);
        chk("first_tick_seg0", 16'(seg_w[0]), 16'h3F);
        repeat (15) step("first_frame");

        // Capture and decode
        pulse(16'h1A5F, "cap");
        for (int c = 0; c < 32; c++) begin
            step("decode");
            for (int d = 0; d < 4; d++)
                if (an_w[0] == 4'(1 << d)) got_seg[d] = seg_w[0];
        end
        chk("dec_d0", 16'(got_seg[0]), 16'h71);
        chk("dec_d1", 16'(got_seg[1]), 16'h6D);
        chk("dec_d2", 16'(got_seg[2]), 16'h77);
        chk("dec_d3", 16'(got_seg[3]), 16'h06);

        // Capture on the same edge as a tick
        guard = 0;
        while (((k + 1) % DIV[0]) != 0 && guard < 8) begin
            step("align");
            guard++;
        end
        chk("align_found", 16'(((k + 1) % DIV[0]) == 0), 16'h1);
        pulse(16'h2C3D, "cap_tick");
        repeat (20) step("cap_tick_after");

        // Leading-zero blanking
        blank_lz = 1'b1;
        pulse(16'h0007, "blank_cap");
        repeat (16) step("blank_warm");
        n0 = 0; nblank = 0;
        for (int c = 0; c < 16; c++) begin
            step("blank");
            if (an_w[0] == 4'b0001) begin
                n0++;
                chk("blank_d0_seg", 16'(seg_w[0]), 16'h07);
            end
            if (an_w[0] == 4'b0000 && seg_w[0] == 7'h00) nblank++;
        end
        chk("blank_d0_cnt", 16'(n0), 16'd4);
        chk("blank_off_cnt", 16'(nblank), 16'd12);
        pulse(16'h0000, "zero_cap");
        repeat (20) step("zero");

        // Decimal point and active-low polarity
        blank_lz = 1'b0;
        dp_mask = 4'b0100;
        pulse(16'h8888, "dp_cap");
        repeat (8) step("dp");
        guard = 0;
        while (an_w[1] != 4'b1011 && guard < 20) begin
            step("dp_wait");
            guard++;
        end
        chk("dp_d2_an", 16'(an_w[1]), 16'hB);
        chk("dp_d2_seg", 16'(seg_w[1]), 16'h00);
        chk("dp_d2_dp", 16'(dp_w[1]), 16'h0);

        // Async reset mid-scan while digit 2 is shown
        guard = 0;
        while (an_w[0] != 4'b0100 && guard < 20) begin
            step("rst_wait");
            guard++;
        end
        chk("rst_digit2", 16'(an_w[0]), 16'h4);
        #2 rst = 1'b1;
        #1;
        check_all("async_rst");
        chk("async_an0", 16'(an_w[0]), 16'h0);
        chk("async_an1", 16'(an_w[1]), 16'hF);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) step("post_rst");
        step("post_rst_tick");
        chk("post_rst_an0", 16'(an_w[0]), 16'h1);
        chk("post_rst_seg0", 16'(seg_w[0]), 16'h3F);
        repeat (12) step("post_rst_frame");

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            value       = 16'($urandom >> $urandom_range(0, 31));
            value_valid = ($urandom_range(0, 4) == 0);
            dp_mask     = 4'($urandom);
            if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b1;
                #1;
                check_all("rnd_rst");
                @(negedge clk);
                rst = 1'b0;
            end
            step("rnd");
        end
        value_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
